instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//  Prefetch buffer between instruction memory and the IF/ID register. Issues sequential fetch
//  requests over a valid/ready channel with variable-latency in-order responses. Queues up to DEPTH
//  {pc,instr} pairs and presents them to decode with valid/ready. Branch redirect flushes the queue,
//  discards in-flight responses and restarts fetch at the target.
// PARAMETERS
//  DEPTH     4   queue entries; also the maximum number of outstanding requests
//  ADDR_W    32  PC / fetch address width
//  DATA_W    32  instruction width
//  RESET_PC  0   first fetch address after reset
//  PC_STEP   4   address increment per sequential fetch
// PORTS
//  clk             in   1       clock; single clock domain
//  rst             in   1       synchronous, active-high reset
//  redirect_valid  in   1       branch taken in decode; flush and refetch
//  redirect_pc     in   ADDR_W  absolute target address
//  imem_req_valid  out  1       fetch request valid
//  imem_req_addr   out  ADDR_W  fetch address
//  imem_req_ready  in   1       memory accepts the request
//  imem_resp_valid in   1       response valid; in request order; always accepted
//  imem_resp_data  in   DATA_W  fetched instruction
//  instr_valid     out  1       queue head valid
//  instr           out  DATA_W  head instruction
//  instr_pc        out  ADDR_W  head PC
//  instr_ready     in   1       decode accepts the head (low = freeze / hazard)
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, resp_pc=RESET_PC, count=0, outstanding=0, drop_cnt=0.
//    imem_req_valid=0 and instr_valid=0 during rst. instr and instr_pc read 0 while empty.
//  - Request: imem_req_valid = !rst && !redirect_valid && (count+outstanding < DEPTH).
//    imem_req_addr = fetch_pc. On handshake, fetch_pc += PC_STEP (wraps mod 2^ADDR_W) and outstanding++.
//    Addr/valid stay stable until ready, unless a redirect occurs.
//  - Response: outstanding-- every response. If drop_cnt>0, discard and decrement drop_cnt.
//    Else push {resp_pc, data} and resp_pc += PC_STEP.
//  - Output: registered queue, no bypass. Response in cycle N gives instr_valid in cycle N+1 at the earliest.
//    Pop on instr_valid && instr_ready. Order is strict FIFO.
//  - Credit rule: count+outstanding <= DEPTH always, so a push never overflows.
//    Push and pop in the same cycle are legal at any occupancy.
//  - Redirect (priority over everything else):
//    - Next cycle: count=0 and fetch_pc=resp_pc=redirect_pc.
//    - drop_cnt = outstanding remaining after this cycle's response. A response in the redirect cycle is itself discarded.
//    - No request is issued in the redirect cycle. A pop handshake in that cycle still counts as delivered.
//  - Redirect while drop_cnt>0: drop_cnt = total outstanding; stale responses of all epochs are dropped.
//  - Back-to-back redirects: the last one wins.
//  - rst mid-operation: all state returns to reset values at once. Memory shares rst and returns no stale responses after it.
//  - Counters are $clog2(DEPTH+1) bits wide. drop_cnt <= outstanding always (assertion).
// STRUCTURE
//  - Shared package: RESET_PC, PC_STEP, INSTR_W, ADDR_W constants; typedef fetch_entry_t {pc, instr}.
//  - Sub-module sync_fifo_flush (DEPTH, WIDTH=ADDR_W+DATA_W): circular buffer with rd/wr pointers,
//    count, and a synchronous flush input.
//  - Top level holds fetch_pc, resp_pc, outstanding, drop_cnt and the request logic.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> req_valid=0, instr_valid=0. Cycle after rst drops -> req_valid=1, addr=0x0.
//  2 Zero-wait memory (ready=1, response 1 cycle later, data=addr^32'hA5A5A5A5), instr_ready=1
//    -> instr_pc 0,4,8,... one per cycle. First instr_valid 2 cycles after the first request handshake.
//  3 Backpressure: instr_ready=0 -> exactly 4 requests (0x0..0xC), then req_valid=0 with count=4.
//    Raise ready -> 4 entries in order, no loss or duplicate, then fetch resumes at 0x10.
//  4 Redirect with 2 outstanding, redirect_pc=0x100 -> next 2 responses dropped.
//    First instr_valid has pc=0x100 and data=0x100^A5A5A5A5.
//  5 Redirect coincident with a response and with a pop; then a second redirect 1 cycle later to 0x200
//    -> all stale data dropped, first delivered pc=0x200.
//  6 Random memory latency 1-5 and random instr_ready over 10k cycles against a reference model
//    -> same pc/instr sequence; credit and drop_cnt assertions never fire.

Source files
------------

// File: rtl/instr_prefetch_queue_pkg.sv
// ============================================================================
// Module : instr_prefetch_queue_pkg
// Brief  : Shared constants, fetch entry type and counter-width helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package instr_prefetch_queue_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_STEP  = 32'h0000_0004;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Occupancy counters must be able to hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_prefetch_queue_fifo.sv
// ============================================================================
// Module : sync_fifo_flush
// Brief  : Circular-buffer FIFO with occupancy count and synchronous flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_flush #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              wr_en,
    input  logic [WIDTH-1:0]                  wr_data,
    input  logic                              rd_en,
    output logic [WIDTH-1:0]                  rd_data,
    output logic                              empty,
    output logic [$clog2(DEPTH+1)-1:0]        count
);
    import instr_prefetch_queue_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign w_rd    = rd_en && !empty;
    assign w_wr    = wr_en && ((r_count != CNT_W'(DEPTH)) || w_rd);
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
        end
    end

    // Storage needs no reset: reads are masked by the empty flag.
    always_ff @(posedge clk) begin
        if (w_wr && !rst && !flush) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
// ============================================================================
// Module : instr_prefetch_queue
// Brief  : Credit-limited instruction prefetcher with redirect flush/drop.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);
    import instr_prefetch_queue_pkg::*;

    localparam int CNT_W = cnt_width(DEPTH);

    logic [ADDR_W-1:0]        r_fetch_pc;
    logic [ADDR_W-1:0]        r_resp_pc;
    logic [CNT_W-1:0]         r_outstanding;
    logic [CNT_W-1:0]         r_drop_cnt;
    logic [CNT_W-1:0]         w_count;
    logic [CNT_W-1:0]         w_out_after_resp;
    logic [CNT_W:0]           w_total;
    logic                     w_req_fire;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_empty;
    logic [ADDR_W+DATA_W-1:0] w_rd_data;

    // Queued entries plus in-flight requests form the credit pool.
    assign w_total          = {1'b0, w_count} + {1'b0, r_outstanding};
    assign imem_req_valid   = !rst && !redirect_valid && (w_total < (CNT_W+1)'(DEPTH));
    assign imem_req_addr    = r_fetch_pc;
    assign w_req_fire       = imem_req_valid && imem_req_ready;
    assign w_out_after_resp = r_outstanding - CNT_W'(imem_resp_valid);
    assign w_push           = imem_resp_valid && !redirect_valid && (r_drop_cnt == '0);

    assign instr_valid = !rst && !w_empty;
    assign w_pop       = instr_valid && instr_ready;
    assign instr_pc    = w_rd_data[ADDR_W+DATA_W-1:DATA_W];
    assign instr       = w_rd_data[DATA_W-1:0];

    sync_fifo_flush #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .wr_en   (w_push),
        .wr_data ({r_resp_pc, imem_resp_data}),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .empty   (w_empty),
        .count   (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // Every request still in flight belongs to a dead path.
            r_fetch_pc    <= redirect_pc;
            r_resp_pc     <= redirect_pc;
            r_outstanding <= w_out_after_resp;
            r_drop_cnt    <= w_out_after_resp;
        end else begin
            r_outstanding <= w_out_after_resp + CNT_W'(w_req_fire);
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            if (imem_resp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + PC_STEP;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_drop_cnt <= r_outstanding)
                else $error("drop_cnt exceeds outstanding");
            assert (w_total <= (CNT_W+1)'(DEPTH))
                else $error("credit overrun: count+outstanding > DEPTH");
            assert (!imem_resp_valid || (r_outstanding != '0))
                else $error("response with no outstanding request");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
// ============================================================================
// Module : tb_instr_prefetch_queue
// Brief  : Randomized scoreboard bench with an epoch-tagged memory model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_prefetch_queue;
    import instr_prefetch_queue_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    instr_prefetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready)
    );

    always #5 clk = ~clk;

    // A request is live only if it was issued in the current fetch epoch.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_pc;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t        mem_q[$];
    fetch_entry_t exp_q[$];
    mreq_t        cur;
    bit           cur_valid;
    int           cyc, epoch, pops;
    int           n_tests, n_fail;
    logic [31:0]  model_fetch_pc;
    int           ready_pct, iready_pct, lat_min, lat_max;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic redir, input logic [31:0] tgt);
        @(negedge clk);
        rst            = r;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        instr_ready    = ($urandom_range(99) < iready_pct);
        cur_valid      = 1'b0;
        if (!r && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            cur       = mem_q.pop_front();
            cur_valid = 1'b1;
        end
        imem_resp_valid = cur_valid;
        imem_resp_data  = cur_valid ? (cur.addr ^ KEY) : 32'h0;
    endtask

    // Monitor: compares DUT outputs with the model state from previous cycles.
    always @(negedge clk) begin : mon
        logic exp_req;
        #1;
        if (rst) begin
            chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
            chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        end else begin
            exp_req = !redirect_valid &&
                      (exp_q.size() + mem_q.size() + int'(cur_valid) < DEPTH);
            chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
            if (imem_req_valid && exp_req)
                chk("req_addr", imem_req_addr, model_fetch_pc);
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_q.size() != 0});
            if (instr_valid && exp_q.size() != 0) begin
                chk("instr_pc", instr_pc, exp_q[0].pc);
                chk("instr", instr, exp_q[0].instr);
                if (instr_ready) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end else if (!instr_valid) begin
                chk("empty_pc", instr_pc, 32'h0);
                chk("empty_instr", instr, 32'h0);
            end
        end
    end

    // Scoreboard: applies this cycle's handshakes to the reference model.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp_q.delete();
            mem_q.delete();
            model_fetch_pc = RESET_PC;
            epoch++;
        end else begin
            if (redirect_valid) begin
                epoch++;
                exp_q.delete();
                model_fetch_pc = redirect_pc;
            end
            if (cur_valid && cur.epoch == epoch)
                exp_q.push_back('{pc: cur.exp_pc, instr: cur.exp_pc ^ KEY});
            if (imem_req_valid && imem_req_ready) begin
                mem_q.push_back('{addr: imem_req_addr, exp_pc: model_fetch_pc, epoch: epoch,
                                  due: cyc + int'($urandom_range(lat_max, lat_min))});
                model_fetch_pc = model_fetch_pc + PC_STEP;
            end
        end
        cyc++;
    end

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        instr_ready = 1'b0; cur_valid = 1'b0;
        cyc = 0; epoch = 0; pops = 0; n_tests = 0; n_fail = 0;
        model_fetch_pc = RESET_PC;
        ready_pct = 100; iready_pct = 100; lat_min = 1; lat_max = 1;

        repeat (2) drive(1'b1, 1'b0, 32'h0);
        // Zero-wait memory, decode always ready.
        repeat (20) drive(1'b0, 1'b0, 32'h0);
        // Decode frozen until the queue holds the full credit, then drained.
        iready_pct = 0;
        repeat (12) drive(1'b0, 1'b0, 32'h0);
        iready_pct = 100;
        repeat (12) drive(1'b0, 1'b0, 32'h0);
        // Redirect with requests in flight.
        lat_min = 2; lat_max = 2;
        repeat (6) drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h100);
        repeat (15) drive(1'b0, 1'b0, 32'h0);
        // Redirect coinciding with response and pop, followed by a second one.
        lat_min = 1; lat_max = 1;
        repeat (8) drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h180);
        drive(1'b0, 1'b1, 32'h200);
        repeat (10) drive(1'b0, 1'b0, 32'h0);
        // Fetch address wrap-around.
        drive(1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (10) drive(1'b0, 1'b0, 32'h0);

        // Random latency, random backpressure, random redirects, one mid-run reset.
        lat_min = 1; lat_max = 5; ready_pct = 70; iready_pct = 60;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000 || i == 5001)
                drive(1'b1, 1'b0, 32'h0);
            else
                drive(1'b0, ($urandom_range(99) < 2), $urandom & 32'hFFFF_FFFC);
        end
        repeat (8) drive(1'b0, 1'b0, 32'h0);

        chk("delivered_enough", {31'b0, pops > 1000}, 32'h1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
